// File: rtl/karatsuba_dot_accumulator.sv
// karatsuba_dot_accumulator: sums a programmed run of multiplier products.
// Optional macro KARATSUBA_ACC_SATURATE_EN clamps on overflow instead of wrapping.
module karatsuba_dot_accumulator #(
  parameter int WIDTH     = 16,
  parameter int ACC_WIDTH = 48,
  parameter int LEN_WIDTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   start_i,
  input  logic [LEN_WIDTH-1:0]   len_i,
  input  logic                   signed_i,
  input  logic                   valid_i,
  input  logic [2*WIDTH-1:0]     product_i,
  output logic                   result_valid_o,
  input  logic                   result_ready_i,
  output logic [ACC_WIDTH-1:0]   result_o,
  output logic                   busy_o,
  output logic                   overflow_o,
  output logic                   drop_o
);

  localparam int PW = 2 * WIDTH;
  localparam int M  = ACC_WIDTH - 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_HOLD
  } state_t;

  state_t                 r_state;
  logic [ACC_WIDTH-1:0]   r_acc;
  logic [ACC_WIDTH-1:0]   r_result;
  logic [LEN_WIDTH-1:0]   r_cnt;
  logic                   r_signed;
  logic                   r_overflow;
  logic                   r_drop;
  logic                   r_result_valid;
  logic                   r_busy;

  logic                   w_launch;
  logic [ACC_WIDTH-1:0]   w_ext;
  logic [ACC_WIDTH:0]     w_sum;
  logic                   w_ovf;
  logic [ACC_WIDTH-1:0]   w_acc_next;
`ifdef KARATSUBA_ACC_SATURATE_EN
  logic [ACC_WIDTH-1:0]   w_clamp;
`endif

  assign w_launch = start_i &&
                    ((r_state == S_IDLE) ||
                     ((r_state == S_HOLD) && result_ready_i));

  // Extend the product to accumulator width, then add with overflow detect
  always_comb begin
    w_ext = {ACC_WIDTH{r_signed & product_i[PW-1]}};
    w_ext[PW-1:0] = product_i;
    w_sum = {1'b0, r_acc} + {1'b0, w_ext};
    if (r_signed)
      w_ovf = (r_acc[M] == w_ext[M]) && (w_sum[M] != r_acc[M]);
    else
      w_ovf = w_sum[ACC_WIDTH];
`ifdef KARATSUBA_ACC_SATURATE_EN
    if (!r_signed)
      w_clamp = '1;
    else if (r_acc[M])
      w_clamp = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    else
      w_clamp = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    if (r_overflow)
      w_acc_next = r_acc;
    else if (w_ovf)
      w_acc_next = w_clamp;
    else
      w_acc_next = w_sum[ACC_WIDTH-1:0];
`else
    w_acc_next = w_sum[ACC_WIDTH-1:0];
`endif
  end

  // Control FSM with registered outputs and the accumulator datapath
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_state        <= S_IDLE;
      r_acc          <= '0;
      r_result       <= '0;
      r_cnt          <= '0;
      r_signed       <= 1'b0;
      r_overflow     <= 1'b0;
      r_drop         <= 1'b0;
      r_result_valid <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      if (valid_i && (r_state != S_ACCUM))
        r_drop <= 1'b1;
      if (w_launch) begin
        r_acc      <= '0;
        r_result   <= '0;
        r_cnt      <= len_i;
        r_signed   <= signed_i;
        r_overflow <= 1'b0;
        r_drop     <= 1'b0;
        if (len_i != '0) begin
          r_state        <= S_ACCUM;
          r_busy         <= 1'b1;
          r_result_valid <= 1'b0;
        end else begin
          r_state        <= S_HOLD;
          r_busy         <= 1'b0;
          r_result_valid <= 1'b1;
        end
      end else begin
        unique case (r_state)
          S_ACCUM: begin
            if (valid_i) begin
              r_acc      <= w_acc_next;
              r_overflow <= r_overflow | w_ovf;
              r_cnt      <= r_cnt - 1'b1;
              if (r_cnt == {{(LEN_WIDTH-1){1'b0}}, 1'b1}) begin
                r_state        <= S_HOLD;
                r_result       <= w_acc_next;
                r_result_valid <= 1'b1;
                r_busy         <= 1'b0;
              end
            end
          end
          S_HOLD: begin
            if (result_ready_i) begin
              r_state        <= S_IDLE;
              r_result       <= '0;
              r_result_valid <= 1'b0;
            end
          end
          S_IDLE: begin
            r_state <= S_IDLE;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign result_valid_o = r_result_valid;
  assign result_o       = r_result;
  assign busy_o         = r_busy;
  assign overflow_o     = r_overflow;
  assign drop_o         = r_drop;

endmodule

// File: tb/tb_karatsuba_dot_accumulator.sv
// tb_karatsuba_dot_accumulator: randomized and directed vectors vs a
// plain-arithmetic dot-product model, on a 48-bit and a 32-bit accumulator.
module tb_karatsuba_dot_accumulator;

  localparam int W   = 16;
  localparam int AW  = 48;
  localparam int AW2 = 32;

  logic          clk = 1'b0;
  logic          rstn;
  logic          start;
  logic [7:0]    len;
  logic          sgn;
  logic          valid;
  logic [31:0]   prod;
  logic          rdy;

  logic          rv_a, busy_a, ov_a, drop_a;
  logic [AW-1:0] res_a;
  logic          rv_b, busy_b, ov_b, drop_b;
  logic [AW2-1:0] res_b;

  int n_tests = 0;
  int n_fail  = 0;

  bit [31:0] pq[$];

  always #5 clk = ~clk;

  karatsuba_dot_accumulator #(
    .WIDTH(W), .ACC_WIDTH(AW), .LEN_WIDTH(8)
  ) u_dut_a (
    .clk_i(clk), .rstn_i(rstn), .start_i(start), .len_i(len),
    .signed_i(sgn), .valid_i(valid), .product_i(prod),
    .result_valid_o(rv_a), .result_ready_i(rdy), .result_o(res_a),
    .busy_o(busy_a), .overflow_o(ov_a), .drop_o(drop_a)
  );

  karatsuba_dot_accumulator #(
    .WIDTH(W), .ACC_WIDTH(AW2), .LEN_WIDTH(8)
  ) u_dut_b (
    .clk_i(clk), .rstn_i(rstn), .start_i(start), .len_i(len),
    .signed_i(sgn), .valid_i(valid), .product_i(prod),
    .result_valid_o(rv_b), .result_ready_i(rdy), .result_o(res_b),
    .busy_o(busy_b), .overflow_o(ov_b), .drop_o(drop_b)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Running integer sum; out-of-range steps wrap or clamp
  function automatic logic [63:0] model(input int aw, input bit s,
                                        output bit ov);
    longint lo, hi, span, acc, v, n;
    span = longint'(1) << aw;
    if (s) begin
      lo = -(span / 2);
      hi = span / 2 - 1;
    end else begin
      lo = 0;
      hi = span - 1;
    end
    acc = 0;
    ov  = 1'b0;
    foreach (pq[i]) begin
      v = s ? longint'($signed(pq[i])) : longint'(pq[i]);
`ifdef KARATSUBA_ACC_SATURATE_EN
      if (ov) continue;
`endif
      n = acc + v;
      if (n > hi || n < lo) begin
        ov = 1'b1;
`ifdef KARATSUBA_ACC_SATURATE_EN
        n = (n > hi) ? hi : lo;
`else
        n = (n > hi) ? n - span : n + span;
`endif
      end
      acc = n;
    end
    return 64'(acc & (span - 1));
  endfunction

  task automatic run_vec(input bit s, input bit hold_drop);
    logic [63:0] ea, eb;
    bit oa, ob;
    int n;
    n  = pq.size();
    ea = model(AW, s, oa);
    eb = model(AW2, s, ob);
    start = 1'b1;
    len   = n[7:0];
    sgn   = s;
    @(negedge clk);
    start = 1'b0;
    if (n > 0) chk("busy_accum", 64'(busy_a), 64'd1);
    foreach (pq[i]) begin
      if ($urandom_range(0, 1) == 1) begin
        valid = 1'b0;
        @(negedge clk);
      end
      valid = 1'b1;
      prod  = pq[i];
      @(negedge clk);
    end
    valid = 1'b0;
    chk("rvalid_a", 64'(rv_a), 64'd1);
    chk("rvalid_b", 64'(rv_b), 64'd1);
    chk("result_a", 64'(res_a), ea);
    chk("result_b", 64'(res_b), eb);
    chk("ovf_a", 64'(ov_a), 64'(oa));
    chk("ovf_b", 64'(ov_b), 64'(ob));
    chk("drop_a", 64'(drop_a), 64'd0);
    chk("busy_hold", 64'(busy_a), 64'd0);
    if (hold_drop) begin
      repeat ($urandom_range(1, 3)) begin
        valid = 1'b1;
        prod  = $urandom;
        @(negedge clk);
      end
      valid = 1'b0;
      @(negedge clk);
      chk("hold_drop", 64'(drop_a), 64'd1);
      chk("hold_stable", 64'(res_a), ea);
      chk("hold_rvalid", 64'(rv_a), 64'd1);
    end
    rdy = 1'b1;
    @(negedge clk);
    rdy = 1'b0;
    chk("rel_rvalid", 64'(rv_a), 64'd0);
    chk("rel_result", 64'(res_a), 64'd0);
  endtask

  initial begin
    rstn  = 1'b0;
    start = 1'b0;
    len   = '0;
    sgn   = 1'b0;
    valid = 1'b0;
    prod  = '0;
    rdy   = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    chk("rst_rvalid", 64'(rv_a), 64'd0);
    chk("rst_result", 64'(res_a), 64'd0);
    chk("rst_busy", 64'(busy_a), 64'd0);
    chk("rst_ovf", 64'(ov_a), 64'd0);
    chk("rst_drop", 64'(drop_a), 64'd0);

    // product while idle is dropped
    valid = 1'b1;
    prod  = 32'h55;
    @(negedge clk);
    valid = 1'b0;
    chk("idle_drop", 64'(drop_a), 64'd1);

    // plan 1, 2, 4, 5
    pq = '{32'd1, 32'd2, 32'd3};
    run_vec(1'b0, 1'b0);
    chk("p1_const", 64'(model(AW, 1'b0, sgn)), 64'h6);
    pq = '{32'hFFFFFFFE, 32'h5};
    run_vec(1'b1, 1'b0);
    run_vec(1'b0, 1'b0);
    pq = {};
    run_vec(1'b0, 1'b0);
    pq = '{32'hFFFFFFFF, 32'hFFFFFFFF};
    run_vec(1'b0, 1'b0);

    // plan 3: backpressure, drop in hold, restart from hold
    start = 1'b1; len = 8'd1; sgn = 1'b0;
    @(negedge clk);
    start = 1'b0; valid = 1'b1; prod = 32'h1234;
    @(negedge clk);
    valid = 1'b0;
    chk("p3_rvalid", 64'(rv_a), 64'd1);
    chk("p3_result", 64'(res_a), 64'h1234);
    @(negedge clk);
    valid = 1'b1; prod = 32'h9999;
    @(negedge clk);
    valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("p3_stable", 64'(res_a), 64'h1234);
    chk("p3_drop", 64'(drop_a), 64'd1);
    rdy = 1'b1; start = 1'b1; len = 8'd1;
    @(negedge clk);
    rdy = 1'b0; start = 1'b0;
    chk("p3_busy", 64'(busy_a), 64'd1);
    chk("p3_drop_clr", 64'(drop_a), 64'd0);
    valid = 1'b1; prod = 32'h5;
    @(negedge clk);
    valid = 1'b0;
    chk("p3_result2", 64'(res_a), 64'h5);
    rdy = 1'b1;
    @(negedge clk);
    rdy = 1'b0;

    // plan 6: reset mid-vector
    start = 1'b1; len = 8'd3; sgn = 1'b0;
    @(negedge clk);
    start = 1'b0; valid = 1'b1; prod = 32'h77;
    @(negedge clk);
    valid = 1'b0; rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    chk("p6_busy", 64'(busy_a), 64'd0);
    chk("p6_rvalid", 64'(rv_a), 64'd0);
    chk("p6_result", 64'(res_a), 64'd0);
    pq = '{32'd7};
    run_vec(1'b0, 1'b0);

    // randomized vectors
    for (int v = 0; v < 40; v++) begin
      int n;
      int mode;
      n = $urandom_range(0, 8);
      pq = {};
      mode = $urandom_range(0, 2);
      for (int k = 0; k < n; k++) begin
        unique case (mode)
          0: pq.push_back($urandom_range(0, 65535));
          1: pq.push_back($urandom);
          default:
            pq.push_back(($urandom_range(0, 1) == 1) ?
                         32'h7FFFFFF0 + $urandom_range(0, 15) :
                         32'h80000000 + $urandom_range(0, 15));
        endcase
      end
      run_vec(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
